// File: rtl/gfx_defs.sv
// Shared graphics definitions for the board-level drawing blocks.
// Holds default coordinate/colour widths, screen bounds, the rectangle
// engine state encoding and a few named colours.
package gfx_defs;

  localparam int DEF_X_W      = 10;
  localparam int DEF_Y_W      = 9;
  localparam int DEF_DIM_W    = 9;
  localparam int DEF_COLOUR_W = 3;
  localparam int DEF_SCREEN_W = 480;
  localparam int DEF_SCREEN_H = 360;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] RED   = 3'b100;

endpackage

// File: rtl/raster_counter.sv
// Column/row walker for the rectangle rasteriser.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   load_i                 restart at (col 0, row 0)
//   step_i                 advance one pixel in raster order (col fastest)
//   width_i, height_i      latched rectangle dimensions
//   col_nxt_o, row_nxt_o   coordinates the counter will hold after this edge
//   last_col_o             current column is the last of its row
//   last_pix_o             current pixel is the last of the rectangle
// The next-state coordinates are exported so the parent can register its
// pixel outputs in the same cycle the counter moves.
module raster_counter #(
  parameter int DIM_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [DIM_W-1:0] width_i,
  input  logic [DIM_W-1:0] height_i,
  output logic [DIM_W-1:0] col_nxt_o,
  output logic [DIM_W-1:0] row_nxt_o,
  output logic             last_col_o,
  output logic             last_pix_o
);

  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;

  assign last_col_o = (col_q == width_i - DIM_W'(1));
  assign last_pix_o = last_col_o && (row_q == height_i - DIM_W'(1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (load_i) begin
      col_d = '0;
      row_d = '0;
    end else if (step_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  assign col_nxt_o = col_d;
  assign row_nxt_o = row_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle rasteriser driving the vga_adapter plot port.
// A start request (accepted only while not busy) latches origin, size,
// colour and fill/outline mode, then one pixel per clock is presented in
// raster order. Off-screen pixels and outline interiors still take a cycle
// but do not strobe plot, so latency depends only on width*height.
// Ports:
//   clock, reset             clock, synchronous active-high reset
//   start                    request strobe
//   x0, y0                   top-left origin
//   width, height            rectangle size, zero means empty
//   colour_in, outline       pixel colour, 1 = perimeter only
//   busy                     high while pixels are being emitted
//   done                     one-cycle completion pulse
//   plot, x, y, colour       pixel write strobe, coordinates and colour
//   dbg_state_o              current FSM state
// Handshake: start is sampled on a rising edge; it is taken when busy is
// low (IDLE or DONE) and ignored entirely while busy is high.
module rect_fill_engine
  import gfx_defs::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int DIM_W    = DEF_DIM_W,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [DIM_W-1:0]    width,
  input  logic [DIM_W-1:0]    height,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                outline,
  output logic                busy,
  output logic                done,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output state_t              dbg_state_o
);

  state_t state_q, state_d;

  logic [X_W-1:0]      x0_q, x0_d;
  logic [Y_W-1:0]      y0_q, y0_d;
  logic [DIM_W-1:0]    w_q, w_d;
  logic [DIM_W-1:0]    h_q, h_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                outline_q, outline_d;

  logic                plot_q, plot_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;

  logic                accept;
  logic                scan_step;
  logic [DIM_W-1:0]    col_nxt, row_nxt;
  logic                last_col, last_pix;

  logic [X_W:0]        x_sum;
  logic [Y_W:0]        y_sum;
  logic                clipped;
  logic                on_edge;

  assign accept    = start && (state_q != ST_SCAN);
  assign scan_step = (state_q == ST_SCAN);

  raster_counter #(
    .DIM_W (DIM_W)
  ) u_raster_counter (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (accept),
    .step_i     (scan_step),
    .width_i    (w_q),
    .height_i   (h_q),
    .col_nxt_o  (col_nxt),
    .row_nxt_o  (row_nxt),
    .last_col_o (last_col),
    .last_pix_o (last_pix)
  );

  // Next state and operand latches.
  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    colour_d  = colour_q;
    outline_d = outline_q;

    if (accept) begin
      x0_d      = x0;
      y0_d      = y0;
      w_d       = width;
      h_d       = height;
      colour_d  = colour_in;
      outline_d = outline;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d = ((width == '0) || (height == '0)) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (last_pix) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel for the coming cycle, computed from next-state values so the
  // output registers line up with state_q == ST_SCAN.
  always_comb begin
    x_sum   = {1'b0, x0_d} + (X_W+1)'(col_nxt);
    y_sum   = {1'b0, y0_d} + (Y_W+1)'(row_nxt);
    clipped = (x_sum >= (X_W+1)'(SCREEN_W)) || (y_sum >= (Y_W+1)'(SCREEN_H));
    // The next column is 0 exactly when restarting or wrapping a row.
    on_edge = !outline_d || accept || last_col ||
              (col_nxt == w_d - DIM_W'(1)) ||
              (row_nxt == '0) || (row_nxt == h_d - DIM_W'(1));
    plot_d  = (state_d == ST_SCAN) && !clipped && on_edge;
    x_d     = x_q;
    y_d     = y_q;
    if (state_d == ST_SCAN) begin
      x_d = x_sum[X_W-1:0];
      y_d = y_sum[Y_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      colour_q  <= '0;
      outline_q <= 1'b0;
      plot_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      colour_q  <= colour_d;
      outline_q <= outline_d;
      plot_q    <= plot_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign busy        = (state_q == ST_SCAN);
  assign done        = (state_q == ST_DONE);
  assign plot        = plot_q;
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;
  import gfx_defs::*;

  localparam int XW = 10;
  localparam int YW = 9;
  localparam int DW = 9;
  localparam int CW = 3;
  localparam int W  = 1 + XW + YW;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [DW-1:0] width;
  logic [DW-1:0] height;
  logic [CW-1:0] colour_in;
  logic          outline;
  logic          busy, done, plot;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  state_t        dbg_state;

  always #5 clock = ~clock;

  rect_fill_engine dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .x0          (x0),
    .y0          (y0),
    .width       (width),
    .height      (height),
    .colour_in   (colour_in),
    .outline     (outline),
    .busy        (busy),
    .done        (done),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];

  int cur_x0, cur_y0, cur_w, cur_h, cur_c;
  bit cur_o;
  int nx_x0, nx_y0, nx_w, nx_h, nx_c;
  bit nx_o;

  // One entry per scan cycle: {plot, x, y} straight from the drawing rules.
  task automatic build_model();
    int xs, ys;
    bit pl, clipped, edge_px;
    logic [XW-1:0] xt;
    logic [YW-1:0] yt;
    exp_q.delete();
    for (int r = 0; r < cur_h; r++) begin
      for (int c = 0; c < cur_w; c++) begin
        xs      = cur_x0 + c;
        ys      = cur_y0 + r;
        clipped = (xs >= 480) || (ys >= 360);
        edge_px = !cur_o || (c == 0) || (c == cur_w - 1) || (r == 0) || (r == cur_h - 1);
        pl      = !clipped && edge_px;
        xt      = xs[XW-1:0];
        yt      = ys[YW-1:0];
        exp_q.push_back({pl, xt, yt});
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_req(input int ax0, input int ay0, input int aw, input int ah,
                           input int ac, input bit ao);
    x0        = ax0[XW-1:0];
    y0        = ay0[YW-1:0];
    width     = aw[DW-1:0];
    height    = ah[DW-1:0];
    colour_in = ac[CW-1:0];
    outline   = ao;
    start     = 1'b1;
    cur_x0 = ax0; cur_y0 = ay0; cur_w = aw; cur_h = ah; cur_c = ac; cur_o = ao;
  endtask

  // Follows a request driven at the previous negedge through to its done
  // pulse. inject_at drops a rogue start mid-scan; chain issues nx_* in the
  // done cycle.
  task automatic check_scan(input string name, input int inject_at, input bit chain,
                            output int plots, output int busy_cyc);
    logic [W-1:0] e;
    logic [CW-1:0] ec;
    int n;
    build_model();
    ec = cur_c[CW-1:0];
    n = exp_q.size();
    plots = 0;
    busy_cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (i == 0) start = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({plot, x, y} !== e) begin
        bad++;
        $display("FAIL %s pix%0d: got plot=%0b x=%0d y=%0d, want plot=%0b x=%0d y=%0d",
                 name, i, plot, x, y, e[W-1], e[W-2:YW], e[YW-1:0]);
      end
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL %s busy%0d: got busy=%0b done=%0b, want busy=1 done=0", name, i, busy, done);
      end
      if (plot === 1'b1) begin
        plots++;
        total++;
        if (colour !== ec) begin
          bad++;
          $display("FAIL %s colour%0d: got %0d want %0d", name, i, colour, ec);
        end
      end
      if (busy === 1'b1) busy_cyc++;
      if (i == inject_at) begin
        x0 = XW'($urandom_range(0, 1023));
        y0 = YW'($urandom_range(0, 511));
        width = DW'($urandom_range(1, 20));
        height = DW'($urandom_range(1, 20));
        colour_in = CW'($urandom_range(0, 7));
        outline = ~cur_o;
        start = 1'b1;
      end
      if (i == inject_at + 1) start = 1'b0;
    end
    @(negedge clock);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || plot !== 1'b0 || dbg_state !== ST_DONE) begin
      bad++;
      $display("FAIL %s done_pulse: got done=%0b busy=%0b plot=%0b st=%0d, want 1 0 0 %0d",
               name, done, busy, plot, dbg_state, ST_DONE);
    end
    if (chain) drive_req(nx_x0, nx_y0, nx_w, nx_h, nx_c, nx_o);
    else start = 1'b0;
    if (!chain) begin
      @(negedge clock);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0 || dbg_state !== ST_IDLE) begin
        bad++;
        $display("FAIL %s after_done: got done=%0b busy=%0b plot=%0b st=%0d, want 0 0 0 %0d",
                 name, done, busy, plot, dbg_state, ST_IDLE);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    x0 = '0; y0 = '0; width = '0; height = '0; colour_in = '0; outline = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0 || x !== '0 || y !== '0 ||
        colour !== '0 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_vals: got busy=%0b done=%0b plot=%0b x=%0d y=%0d colour=%0d st=%0d, want all 0",
               busy, done, plot, x, y, colour, dbg_state);
    end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%0b done=%0b plot=%0b, want 0 0 0", busy, done, plot);
    end
  endtask

  task automatic test_fill();
    int p, b;
    drive_req(1, 1, 10, 10, BLUE, 1'b0);
    check_scan("fill", -1, 1'b0, p, b);
    total++;
    if (p !== 100) begin bad++; $display("FAIL fill_plots: got %0d want 100", p); end
    total++;
    if (b !== 100) begin bad++; $display("FAIL fill_busy: got %0d want 100", b); end
  endtask

  task automatic test_outline();
    int p, b;
    drive_req(0, 0, 4, 3, RED, 1'b1);
    check_scan("outline", -1, 1'b0, p, b);
    total++;
    if (p !== 10) begin bad++; $display("FAIL outline_plots: got %0d want 10", p); end
    total++;
    if (b !== 12) begin bad++; $display("FAIL outline_busy: got %0d want 12", b); end
    drive_req(5, 5, 1, 4, BLUE, 1'b1);
    check_scan("outline_w1", -1, 1'b0, p, b);
    total++;
    if (p !== 4) begin bad++; $display("FAIL outline_w1_plots: got %0d want 4", p); end
  endtask

  task automatic test_clip();
    int p, b;
    drive_req(476, 358, 8, 4, BLUE, 1'b0);
    check_scan("clip", -1, 1'b0, p, b);
    total++;
    if (p !== 8) begin bad++; $display("FAIL clip_plots: got %0d want 8", p); end
    total++;
    if (b !== 32) begin bad++; $display("FAIL clip_busy: got %0d want 32", b); end
    drive_req(1020, 0, 8, 1, RED, 1'b0);
    check_scan("clip_carry", -1, 1'b0, p, b);
    total++;
    if (p !== 0) begin bad++; $display("FAIL clip_carry_plots: got %0d want 0", p); end
  endtask

  task automatic test_empty();
    int p, b;
    drive_req(3, 3, 0, 5, RED, 1'b0);
    check_scan("empty_w0", -1, 1'b0, p, b);
    total++;
    if (b !== 0 || p !== 0) begin bad++; $display("FAIL empty_w0: got busy=%0d plots=%0d want 0 0", b, p); end
    drive_req(3, 3, 7, 0, RED, 1'b1);
    check_scan("empty_h0", -1, 1'b0, p, b);
    total++;
    if (b !== 0 || p !== 0) begin bad++; $display("FAIL empty_h0: got busy=%0d plots=%0d want 0 0", b, p); end
  endtask

  task automatic test_back_to_back();
    int p, b;
    drive_req(10, 10, 6, 7, RED, 1'b0);
    nx_x0 = 100; nx_y0 = 50; nx_w = 3; nx_h = 2; nx_c = BLUE; nx_o = 1'b1;
    check_scan("b2b_first", 5, 1'b1, p, b);
    total++;
    if (p !== 42) begin bad++; $display("FAIL b2b_first_plots: got %0d want 42", p); end
    check_scan("b2b_second", -1, 1'b0, p, b);
    total++;
    if (p !== 6) begin bad++; $display("FAIL b2b_second_plots: got %0d want 6", p); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    int p, b;
    drive_req(10, 20, 50, 2, RED, 1'b0);
    build_model();
    for (int i = 0; i <= 37; i++) begin
      @(negedge clock);
      if (i == 0) start = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({plot, x, y} !== e) begin
        bad++;
        $display("FAIL reset_mid pix%0d: got plot=%0b x=%0d y=%0d, want plot=%0b x=%0d y=%0d",
                 i, plot, x, y, e[W-1], e[W-2:YW], e[YW-1:0]);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    total++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || x !== '0 || y !== '0 || colour !== '0) begin
      bad++;
      $display("FAIL reset_mid_abort: got plot=%0b busy=%0b done=%0b x=%0d y=%0d colour=%0d, want all 0",
               plot, busy, done, x, y, colour);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_quiet%0d: got done=%0b busy=%0b want 0 0", i, done, busy);
      end
    end
    drive_req(2, 3, 5, 5, BLUE, 1'b1);
    check_scan("after_reset", -1, 1'b0, p, b);
    total++;
    if (p !== 16) begin bad++; $display("FAIL after_reset_plots: got %0d want 16", p); end
  endtask

  task automatic pick_next();
    nx_x0 = ($urandom_range(0, 1) == 1) ? $urandom_range(465, 479) : $urandom_range(0, 1023);
    nx_y0 = ($urandom_range(0, 1) == 1) ? $urandom_range(345, 359) : $urandom_range(0, 511);
    nx_w  = $urandom_range(0, 12);
    nx_h  = $urandom_range(0, 12);
    nx_c  = $urandom_range(0, 7);
    nx_o  = 1'($urandom_range(0, 1));
  endtask

  task automatic test_random();
    int p, b;
    bit chain;
    pick_next();
    drive_req(nx_x0, nx_y0, nx_w, nx_h, nx_c, nx_o);
    for (int k = 0; k < 12; k++) begin
      pick_next();
      chain = (k < 11) && ($urandom_range(0, 1) == 1);
      check_scan("random", -1, chain, p, b);
      if (!chain && k < 11) drive_req(nx_x0, nx_y0, nx_w, nx_h, nx_c, nx_o);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_fill();
    test_outline();
    test_clip();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
